// File: rtl/inst_decompose_pipe_if.sv
// Bundle bus between fetch/RF-read, the decompose pipe and the rename/map stage.
// Carries the producer handshake, the same-cycle RF read port and the consumer
// handshake. The "slave" modport is the decompose pipe's view. The "master"
// modport is the view of the surrounding producer and consumer.
interface inst_decompose_pipe_if #(
    parameter int XLEN    = 32,
    parameter int ISSUE_W = 2,
    parameter int CTRL_W  = 5
);
    localparam int PKT_W = 2*XLEN + 2 + 5 + CTRL_W;

    logic                       in_valid;
    logic                       in_ready;
    logic [ISSUE_W-1:0]         in_lane_vld;
    logic [ISSUE_W*32-1:0]      in_inst;
    logic [ISSUE_W*XLEN-1:0]    in_pc;
    logic [ISSUE_W*5-1:0]       rf_rs1;
    logic [ISSUE_W*5-1:0]       rf_rs2;
    logic [ISSUE_W*XLEN-1:0]    rf_s1;
    logic [ISSUE_W*XLEN-1:0]    rf_s2;
    logic [ISSUE_W-1:0]         rf_rs1_vld;
    logic [ISSUE_W-1:0]         rf_rs2_vld;
    logic                       out_valid;
    logic                       out_ready;
    logic [ISSUE_W*PKT_W-1:0]   out_pkt;
    logic [ISSUE_W-1:0]         out_map_en;

    modport master (
        output in_valid, in_lane_vld, in_inst, in_pc,
        output rf_s1, rf_s2, rf_rs1_vld, rf_rs2_vld, out_ready,
        input  in_ready, rf_rs1, rf_rs2, out_valid, out_pkt, out_map_en
    );

    modport slave (
        input  in_valid, in_lane_vld, in_inst, in_pc,
        input  rf_s1, rf_s2, rf_rs1_vld, rf_rs2_vld, out_ready,
        output in_ready, rf_rs1, rf_rs2, out_valid, out_pkt, out_map_en
    );
endinterface

// File: rtl/inst_decompose_pipe.sv
// inst_decompose_pipe: splits each fetched bundle into per-lane rename packets
// {s2_vt, s2_valid, s1_vt, s1_valid, rd, ctrl}. The bundles are then queued in a
// DEPTH-entry FIFO ahead of the rename/map stage.
// Optional feature macro: INST_DECOMP_LDST_EN. When it is defined, loads
// (class 5) and stores (class 6) are also decoded. Otherwise both decode as
// illegal (class 0).
// Only control state (count, pointers) is reset. The packet storage is not
// reset, because out_pkt is forced to zero whenever the FIFO is empty.
module inst_decompose_pipe #(
    parameter int XLEN    = 32,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 4,
    parameter int CTRL_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    inst_decompose_pipe_if.slave bus
);
    localparam int PKT_W = 2*XLEN + 2 + 5 + CTRL_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] CLS_NONE  = 3'd0;
    localparam logic [2:0] CLS_REG   = 3'd1;
    localparam logic [2:0] CLS_IMM   = 3'd2;
    localparam logic [2:0] CLS_LUI   = 3'd3;
    localparam logic [2:0] CLS_AUIPC = 3'd4;
    localparam logic [2:0] CLS_LOAD  = 3'd5;
    localparam logic [2:0] CLS_STORE = 3'd6;

    // Sign-extend a 12-bit I-type immediate to XLEN.
    function automatic logic [XLEN-1:0] sext12(input logic signed [11:0] imm);
        logic signed [XLEN-1:0] ext;
        ext = XLEN'(imm);
        return ext;
    endfunction

    // U-type immediate: inst[31:12] placed in the upper bits, low 12 bits cleared.
    function automatic logic [XLEN-1:0] upper20(input logic [31:0] inst);
        return XLEN'({inst[31:12], 12'b0});
    endfunction

    // Decode one lane. The result is {map_en, packet}.
    // A source that is not ready carries its register index as a tag,
    // zero-extended to XLEN, instead of a value.
    function automatic logic [PKT_W:0] decode_lane(
        input logic              lane_vld,
        input logic [31:0]       inst,
        input logic [XLEN-1:0]   pc,
        input logic [XLEN-1:0]   s1,
        input logic [XLEN-1:0]   s2,
        input logic              s1_rdy,
        input logic              s2_rdy
    );
        logic [XLEN-1:0]   s1_vt;
        logic [XLEN-1:0]   s2_vt;
        logic [XLEN-1:0]   s1_reg;
        logic [XLEN-1:0]   s2_reg;
        logic              s1_valid;
        logic              s2_valid;
        logic              map_en;
        logic [4:0]        rd;
        logic [2:0]        cls;
        logic [2:0]        funct3;
        logic [CTRL_W-1:0] ctrl;

        funct3   = inst[14:12];
        s1_reg   = s1_rdy ? s1 : XLEN'(inst[19:15]);
        s2_reg   = s2_rdy ? s2 : XLEN'(inst[24:20]);
        s1_vt    = '0;
        s2_vt    = '0;
        s1_valid = 1'b1;
        s2_valid = 1'b1;
        rd       = inst[11:7];
        cls      = CLS_NONE;

        case (inst[6:0])
            OP_REG: begin
                s1_vt    = s1_reg;
                s1_valid = s1_rdy;
                s2_vt    = s2_reg;
                s2_valid = s2_rdy;
                cls      = CLS_REG;
            end
            OP_IMM: begin
                s1_vt    = s1_reg;
                s1_valid = s1_rdy;
                // Shifts (slli/srli/srai) carry the unsigned shamt, not the 12-bit immediate.
                s2_vt    = (funct3 == 3'b001 || funct3 == 3'b101) ?
                           XLEN'(inst[24:20]) : sext12(inst[31:20]);
                cls      = CLS_IMM;
            end
            OP_LUI: begin
                s2_vt = upper20(inst);
                cls   = CLS_LUI;
            end
            OP_AUIPC: begin
                s1_vt = pc;
                s2_vt = upper20(inst);
                cls   = CLS_AUIPC;
            end
`ifdef INST_DECOMP_LDST_EN
            OP_LOAD: begin
                s1_vt    = s1_reg;
                s1_valid = s1_rdy;
                s2_vt    = sext12(inst[31:20]);
                cls      = CLS_LOAD;
            end
            OP_STORE: begin
                // s2 carries the store data. The rd field holds immediate bits and has no meaning here.
                s1_vt    = s1_reg;
                s1_valid = s1_rdy;
                s2_vt    = s2_reg;
                s2_valid = s2_rdy;
                rd       = 5'd0;
                cls      = CLS_STORE;
            end
`endif
            default: cls = CLS_NONE;
        endcase

        // Invalid lanes and illegal opcodes become an inert, fully "ready" packet.
        if (!lane_vld || cls == CLS_NONE) begin
            s1_vt    = '0;
            s2_vt    = '0;
            s1_valid = 1'b1;
            s2_valid = 1'b1;
            rd       = 5'd0;
            cls      = CLS_NONE;
        end

        if (CTRL_W >= 6)
            ctrl = (cls == CLS_NONE) ? '0 : CTRL_W'({funct3, cls});
        else
            ctrl = CTRL_W'(cls);

        map_en = lane_vld && (cls != CLS_NONE) && (rd != 5'd0);
        return {map_en, s2_vt, s2_valid, s1_vt, s1_valid, rd, ctrl};
    endfunction

    logic [ISSUE_W*PKT_W-1:0] bundle_pkt_p0;
    logic [ISSUE_W-1:0]       bundle_map_p0;
    logic                     push_p0;

    logic [ISSUE_W*PKT_W-1:0] pkt_mem_p1 [DEPTH];
    logic [ISSUE_W-1:0]       map_mem_p1 [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic                     vld_p1;
    logic                     pop_p1;

    // ---- stage p0: combinational lane decode on the incoming bundle ----

    // Register-file read addresses go straight from the raw instruction fields.
    always_comb begin
        bus.rf_rs1 = '0;
        bus.rf_rs2 = '0;
        for (int l = 0; l < ISSUE_W; l++) begin
            bus.rf_rs1[l*5 +: 5] = bus.in_inst[l*32+15 +: 5];
            bus.rf_rs2[l*5 +: 5] = bus.in_inst[l*32+20 +: 5];
        end
    end

    // Build the rename packet and map enable for every lane of the offered bundle.
    always_comb begin
        logic [PKT_W:0] lane_dec;
        lane_dec      = '0;
        bundle_pkt_p0 = '0;
        bundle_map_p0 = '0;
        for (int l = 0; l < ISSUE_W; l++) begin
            lane_dec = decode_lane(bus.in_lane_vld[l],
                                   bus.in_inst[l*32 +: 32],
                                   bus.in_pc[l*XLEN +: XLEN],
                                   bus.rf_s1[l*XLEN +: XLEN],
                                   bus.rf_s2[l*XLEN +: XLEN],
                                   bus.rf_rs1_vld[l],
                                   bus.rf_rs2_vld[l]);
            bundle_pkt_p0[l*PKT_W +: PKT_W] = lane_dec[PKT_W-1:0];
            bundle_map_p0[l]                = lane_dec[PKT_W];
        end
    end

    assign bus.in_ready = (count < CNT_W'(DEPTH));
    assign push_p0      = bus.in_valid && bus.in_ready && !flush;

    // ---- stage p1: bundle FIFO feeding rename/map ----

    assign vld_p1         = (count != '0);
    assign pop_p1         = vld_p1 && bus.out_ready && !flush;
    assign bus.out_valid  = vld_p1;
    assign bus.out_pkt    = vld_p1 ? pkt_mem_p1[rd_ptr] : '0;
    assign bus.out_map_en = vld_p1 ? map_mem_p1[rd_ptr] : '0;

    // Capture the decoded bundle into the tail slot on every accepted push.
    always_ff @(posedge clk) begin
        if (push_p0) begin
            pkt_mem_p1[wr_ptr] <= bundle_pkt_p0;
            map_mem_p1[wr_ptr] <= bundle_map_p0;
        end
    end

    // Occupancy and pointer bookkeeping. Flush empties the FIFO and overrides any push or pop that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_p0)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_p1)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_p0, pop_p1})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_decompose_pipe.sv
// Testbench for inst_decompose_pipe at default parameters (XLEN=32, ISSUE_W=2,
// DEPTH=4, CTRL_W=5). Expected values follow INST_DECOMP_LDST_EN when defined.
module tb_inst_decompose_pipe;
    localparam int XLEN = 32, ISSUE_W = 2, DEPTH = 4, CTRL_W = 5;
    localparam int PKT_W = 2*XLEN + 2 + 5 + CTRL_W;

    logic clk, rst, flush;
    int   n_tests, n_fail;

    inst_decompose_pipe_if #(.XLEN(XLEN), .ISSUE_W(ISSUE_W), .CTRL_W(CTRL_W)) bus_if ();

    inst_decompose_pipe #(.XLEN(XLEN), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .CTRL_W(CTRL_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          lv;
        logic [31:0] inst, pc, s1, s2;
        bit          v1, v2;
        logic [31:0] e_s1;
        bit          e_s1v;
        logic [31:0] e_s2;
        bit          e_s2v;
        logic [4:0]  e_rd;
        logic [2:0]  e_cls;
        bit          e_map;
    } vec_t;

    typedef struct packed {
        logic [1:0]   map;
        logic [151:0] pkt;
    } ent_t;

    vec_t       vecs[$];
    ent_t       q[$];
    logic [6:0] ops[8];

    function automatic vec_t mkv(bit lv, logic [31:0] inst, pc, s1, s2, bit v1, v2,
                                 logic [31:0] e_s1, bit e_s1v, logic [31:0] e_s2, bit e_s2v,
                                 logic [4:0] e_rd, logic [2:0] e_cls, bit e_map);
        vec_t v;
        v.lv = lv; v.inst = inst; v.pc = pc; v.s1 = s1; v.s2 = s2; v.v1 = v1; v.v2 = v2;
        v.e_s1 = e_s1; v.e_s1v = e_s1v; v.e_s2 = e_s2; v.e_s2v = e_s2v;
        v.e_rd = e_rd; v.e_cls = e_cls; v.e_map = e_map;
        return v;
    endfunction

    function automatic logic [75:0] mkpkt(logic [31:0] s2, bit s2v, logic [31:0] s1, bit s1v,
                                          logic [4:0] rd, logic [2:0] cls);
        return {s2, s2v, s1, s1v, rd, 2'b00, cls};
    endfunction

    // Reference decode of one lane from the instruction-set rules; returns {map_en, packet}.
    function automatic logic [76:0] ref_lane(bit lv, logic [31:0] inst, pc, s1, s2, bit v1, v2);
        int          cls;
        logic [31:0] a, b, r1val, r2val, immi, immu;
        bit          av, bv;
        logic [4:0]  rd;
        r1val = v1 ? s1 : {27'd0, inst[19:15]};
        r2val = v2 ? s2 : {27'd0, inst[24:20]};
        immi  = $signed(inst) >>> 20;
        immu  = inst & 32'hFFFF_F000;
        cls = 0; a = 0; b = 0; av = 1; bv = 1; rd = inst[11:7];
        case (inst[6:0])
            7'h33: begin cls = 1; a = r1val; av = v1; b = r2val; bv = v2; end
            7'h13: begin cls = 2; a = r1val; av = v1;
                         b = (inst[13:12] == 2'b01) ? {27'd0, inst[24:20]} : immi; end
            7'h37: begin cls = 3; b = immu; end
            7'h17: begin cls = 4; a = pc; b = immu; end
`ifdef INST_DECOMP_LDST_EN
            7'h03: begin cls = 5; a = r1val; av = v1; b = immi; end
            7'h23: begin cls = 6; a = r1val; av = v1; b = r2val; bv = v2; rd = 0; end
`endif
            default: cls = 0;
        endcase
        if (!lv || cls == 0) return {1'b0, mkpkt(0, 1, 0, 1, 0, 0)};
        return {(rd != 0), mkpkt(b, bv, a, av, rd, 3'(cls))};
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_lane(input int l, input bit lv, input logic [31:0] inst, pc, s1, s2,
                            input bit v1, v2);
        bus_if.in_lane_vld[l]          = lv;
        bus_if.in_inst[l*32 +: 32]     = inst;
        bus_if.in_pc[l*XLEN +: XLEN]   = pc;
        bus_if.rf_s1[l*XLEN +: XLEN]   = s1;
        bus_if.rf_s2[l*XLEN +: XLEN]   = s2;
        bus_if.rf_rs1_vld[l]           = v1;
        bus_if.rf_rs2_vld[l]           = v2;
    endtask

    // Drive a random two-lane bundle and return what the model expects from it.
    task automatic set_rand_bundle(output ent_t e);
        logic [76:0] r;
        e = '0;
        for (int l = 0; l < 2; l++) begin
            logic [31:0] x, inst, pc, s1, s2;
            bit lv, v1, v2;
            x    = $urandom();
            inst = {x[31:7], ops[$urandom_range(0, 7)]};
            pc   = $urandom();
            s1   = $urandom();
            s2   = $urandom();
            lv   = ($urandom_range(0, 7) != 0);
            v1   = $urandom_range(0, 1) == 1;
            v2   = $urandom_range(0, 1) == 1;
            set_lane(l, lv, inst, pc, s1, s2, v1, v2);
            r = ref_lane(lv, inst, pc, s1, s2, v1, v2);
            e.pkt[l*76 +: 76] = r[75:0];
            e.map[l]          = r[76];
        end
    endtask

    initial begin
        ent_t        t4_exp[4];
        ent_t        e;
        logic [75:0] zero_lane;
        bit          fl, do_push, do_pop;

        n_tests = 0; n_fail = 0;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h7F, 7'h63};
        zero_lane = mkpkt(0, 1, 0, 1, 0, 0);

        vecs.push_back(mkv(1, 32'h002081B3, 0, 32'h10, 32'hDEAD, 1, 0, 32'h10, 1, 32'h2, 0, 3, 1, 1));
        vecs.push_back(mkv(1, 32'hFFF00293, 0, 32'h0, 32'h0, 1, 1, 32'h0, 1, 32'hFFFFFFFF, 1, 5, 2, 1));
        vecs.push_back(mkv(1, 32'h00309213, 0, 32'h99, 32'h0, 0, 1, 32'h1, 0, 32'h3, 1, 4, 2, 1));
        vecs.push_back(mkv(1, 32'h123450B7, 0, 32'h5, 32'h6, 1, 1, 32'h0, 1, 32'h12345000, 1, 1, 3, 1));
        vecs.push_back(mkv(1, 32'h00001117, 32'h100, 32'h5, 32'h6, 1, 1, 32'h100, 1, 32'h1000, 1, 2, 4, 1));
`ifdef INST_DECOMP_LDST_EN
        vecs.push_back(mkv(1, 32'h0080A303, 0, 32'h55, 32'h0, 1, 1, 32'h55, 1, 32'h8, 1, 6, 5, 1));
        vecs.push_back(mkv(1, 32'h0020A223, 0, 32'h55, 32'h77, 1, 1, 32'h55, 1, 32'h77, 1, 0, 6, 0));
`else
        vecs.push_back(mkv(1, 32'h0080A303, 0, 32'h55, 32'h0, 1, 1, 32'h0, 1, 32'h0, 1, 0, 0, 0));
        vecs.push_back(mkv(1, 32'h0020A223, 0, 32'h55, 32'h77, 1, 1, 32'h0, 1, 32'h0, 1, 0, 0, 0));
`endif
        vecs.push_back(mkv(1, 32'h00208033, 0, 32'h7, 32'h8, 0, 0, 32'h1, 0, 32'h2, 0, 0, 1, 0));
        vecs.push_back(mkv(0, 32'h002081B3, 0, 32'h10, 32'h20, 1, 1, 32'h0, 1, 32'h0, 1, 0, 0, 0));
        vecs.push_back(mkv(1, 32'h0000007F, 0, 32'h10, 32'h20, 1, 1, 32'h0, 1, 32'h0, 1, 0, 0, 0));

        // Reset state
        rst = 1'b1; flush = 1'b0;
        bus_if.in_valid = 1'b0; bus_if.out_ready = 1'b0;
        bus_if.in_lane_vld = '0; bus_if.in_inst = '0; bus_if.in_pc = '0;
        bus_if.rf_s1 = '0; bus_if.rf_s2 = '0; bus_if.rf_rs1_vld = '0; bus_if.rf_rs2_vld = '0;
        #12;
        chk("reset_out_valid", bus_if.out_valid, 1'b0);
        chk("reset_in_ready", bus_if.in_ready, 1'b1);
        chk("reset_out_pkt", bus_if.out_pkt, '0);
        chk("reset_map_en", bus_if.out_map_en, '0);
        #4 rst = 1'b0;

        // Table-driven single-lane decode vectors (lane 1 left invalid)
        bus_if.out_ready = 1'b1;
        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            set_lane(0, v.lv, v.inst, v.pc, v.s1, v.s2, v.v1, v.v2);
            set_lane(1, 0, $urandom(), $urandom(), $urandom(), $urandom(), 1, 1);
            bus_if.in_valid = 1'b1;
            #1;
            chk($sformatf("vec%0d_rf_rs1", i), bus_if.rf_rs1[4:0], v.inst[19:15]);
            chk($sformatf("vec%0d_rf_rs2", i), bus_if.rf_rs2[4:0], v.inst[24:20]);
            @(posedge clk); #1;
            bus_if.in_valid = 1'b0;
            chk($sformatf("vec%0d_out_valid", i), bus_if.out_valid, 1'b1);
            chk($sformatf("vec%0d_out_pkt", i), bus_if.out_pkt,
                {zero_lane, mkpkt(v.e_s2, v.e_s2v, v.e_s1, v.e_s1v, v.e_rd, v.e_cls)});
            chk($sformatf("vec%0d_map_en", i), bus_if.out_map_en, {1'b0, v.e_map});
            @(posedge clk); #1;
        end
        chk("table_drained", bus_if.out_valid, 1'b0);

        // Full FIFO with backpressure, then ordered drain across pointer wrap
        bus_if.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_rand_bundle(t4_exp[k]);
            bus_if.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        set_rand_bundle(e);
        chk("full_in_ready", bus_if.in_ready, 1'b0);
        chk("full_head", bus_if.out_pkt, t4_exp[0].pkt);
        @(posedge clk); #1;
        chk("full_hold_in_ready", bus_if.in_ready, 1'b0);
        chk("full_hold_head", bus_if.out_pkt, t4_exp[0].pkt);
        chk("full_hold_map", bus_if.out_map_en, t4_exp[0].map);
        bus_if.in_valid = 1'b0;
        bus_if.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_pkt", k), bus_if.out_pkt, t4_exp[k].pkt);
            chk($sformatf("drain%0d_map", k), bus_if.out_map_en, t4_exp[k].map);
            @(posedge clk); #1;
        end
        chk("drain_empty_valid", bus_if.out_valid, 1'b0);
        chk("drain_empty_pkt", bus_if.out_pkt, '0);

        // Flush with three bundles queued and a fourth offered
        bus_if.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_rand_bundle(e);
            bus_if.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("flush_pre_valid", bus_if.out_valid, 1'b1);
        set_rand_bundle(e);
        flush = 1'b1;
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        bus_if.in_valid = 1'b0;
        chk("flush_out_valid", bus_if.out_valid, 1'b0);
        chk("flush_in_ready", bus_if.in_ready, 1'b1);
        chk("flush_out_pkt", bus_if.out_pkt, '0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("flush_stays_empty", bus_if.out_valid, 1'b0);
        end
        set_rand_bundle(e);
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        chk("post_flush_pkt", bus_if.out_pkt, e.pkt);
        chk("post_flush_map", bus_if.out_map_en, e.map);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of traffic
        bus_if.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_rand_bundle(e);
            bus_if.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus_if.out_valid, 1'b0);
        chk("midrst_out_pkt", bus_if.out_pkt, '0);
        chk("midrst_in_ready", bus_if.in_ready, 1'b1);
        chk("midrst_map_en", bus_if.out_map_en, '0);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        #2 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("after_rst_idle", bus_if.out_valid, 1'b0);
        end

        // Randomized traffic against the queue model
        q.delete();
        for (int c = 0; c < 400; c++) begin
            chk("rnd_out_valid", bus_if.out_valid, q.size() != 0);
            chk("rnd_in_ready", bus_if.in_ready, q.size() < DEPTH);
            if (q.size() != 0) begin
                chk("rnd_out_pkt", bus_if.out_pkt, q[0].pkt);
                chk("rnd_map_en", bus_if.out_map_en, q[0].map);
            end else begin
                chk("rnd_empty_pkt", bus_if.out_pkt, '0);
            end
            set_rand_bundle(e);
            bus_if.in_valid  = ($urandom_range(0, 9) < 7);
            bus_if.out_ready = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 15) == 0);
            flush = fl;
            do_push = bus_if.in_valid && (q.size() < DEPTH) && !fl;
            do_pop  = (q.size() != 0) && bus_if.out_ready && !fl;
            @(posedge clk); #1;
            if (fl) q.delete();
            else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(e);
            end
        end
        flush = 1'b0;
        bus_if.in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
